seg_scan_display: RTL and testbench

//  Parametrised, time-multiplexed N-digit 7-segment driver; replaces the static 28-bit seg bus.

---
 rtl/seg_pkg.sv | 49 ++++
 rtl/bcd_to_seg7.sv | 20 ++
 rtl/seg_scan_display.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_display.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seg_pkg                                                      |
// | Description : Shared constants and the digit-to-glyph decode function      |
// |               for the scanned 7-segment display.                           |
// |               Glyphs are logical (active-high) in the order {g,f,e,d,c,b,a}.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  // 0-9 give the usual glyphs, 4'hA a dash; every other code is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    logic [6:0] s;
    case (dig)
      4'd0:     s = SEG_0;
      4'd1:     s = SEG_1;
      4'd2:     s = SEG_2;
      4'd3:     s = SEG_3;
      4'd4:     s = SEG_4;
      4'd5:     s = SEG_5;
      4'd6:     s = SEG_6;
      4'd7:     s = SEG_7;
      4'd8:     s = SEG_8;
      4'd9:     s = SEG_9;
      DIG_DASH: s = SEG_DASH;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_to_seg7                                                  |
// | Description : Combinational digit-code to logical 7-segment glyph decoder. |
// | Ports       : digit [3:0] in  - digit code                                 |
// |               seg   [6:0] out - logical glyph {g,f,e,d,c,b,a}, 1 = lit     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_to_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import seg_pkg::*;

  always_comb begin
    seg = seg_decode(digit);
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_display                                             |
// | Description : Time-multiplexed N-digit 7-segment driver. One digit is lit  |
// |               per slot (one-hot an, shared seg/dp). The displayed value is |
// |               double-buffered and swapped only at the frame wrap, with     |
// |               per-digit blank, blink and decimal-point control.            |
// | Ports       : clk, resetn (async, active-low)                              |
// |               digits_in [4*N-1:0] in  - digit codes, digit 0 rightmost     |
// |               load                in  - capture digits_in (1-cycle strobe) |
// |               blank_mask/blink_mask/dp_mask [N-1:0] in - live masks        |
// |               an [N-1:0] out, seg [6:0] out, dp out - board pins           |
// |               frame_done out - 1-cycle pulse after each frame wrap         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);
  import seg_pkg::*;

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  C_FC_MAX  = FC_W'(BLINK_FRAMES - 1);

  // Pin polarity is applied as an XOR mask on the output register only.
  localparam logic                  C_INV     = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF  = {NUM_DIGITS{C_INV}};
  localparam logic [6:0]            C_SEG_OFF = {7{C_INV}};

  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    r_phase;
  logic [FC_W-1:0]         r_fcnt;
  logic                    r_slot_start;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_digit;
  logic [6:0]            w_seg_dec;
  logic                  w_dark;
  logic [6:0]            w_seg_lit;
  logic                  w_dp_lit;
  logic [NUM_DIGITS-1:0] w_an_lit;
  logic [3:0]            w_dig_arr [NUM_DIGITS];

  assign w_tick = (r_pre == C_PRE_MAX);
  assign w_wrap = w_tick && (r_idx == C_IDX_MAX);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_split
      assign w_dig_arr[gi] = r_active[4*gi +: 4];
    end
  endgenerate

  assign w_digit = w_dig_arr[r_idx];

  bcd_to_seg7 u_dec (
    .digit (w_digit),
    .seg   (w_seg_dec)
  );

  assign w_dark    = blank_mask[r_idx] | (blink_mask[r_idx] & r_phase);
  assign w_seg_lit = w_dark ? SEG_BLANK : w_seg_dec;
  assign w_dp_lit  = ~w_dark & dp_mask[r_idx];
  assign w_an_lit  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  // Prescaler and scan index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_slot_start <= 1'b0;
    end else begin
      r_pre        <= w_tick ? '0 : r_pre + 1'b1;
      r_slot_start <= w_tick;
      if (w_tick) begin
        r_idx <= (r_idx == C_IDX_MAX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow/active double buffer. A load coinciding with the wrap bypasses
  // the shadow so the new value is shown on the very next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load && w_wrap) begin
        r_active  <= digits_in;
        r_shadow  <= digits_in;
        r_pending <= 1'b0;
      end else if (w_wrap && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow  <= digits_in;
        r_pending <= 1'b1;
      end
    end
  end

  // Blink phase flips every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_fcnt == C_FC_MAX) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Output register. The tick edge blanks everything (anti-ghosting gap);
  // the following edge latches the new slot's pattern, which is then held
  // for the rest of the slot, so live mask changes land on the next slot.
  // frame_done is high during the gap cycle that opens the new frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an         <= C_AN_OFF;
      seg        <= C_SEG_OFF;
      dp         <= C_INV;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      if (w_tick) begin
        an  <= C_AN_OFF;
        seg <= C_SEG_OFF;
        dp  <= C_INV;
      end else if (r_slot_start) begin
        an  <= w_an_lit ^ C_AN_OFF;
        seg <= w_seg_lit ^ C_SEG_OFF;
        dp  <= w_dp_lit ^ C_INV;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_scan_display                                          |
// | Description : Self-checking bench for seg_scan_display (4 digits,          |
// |               SCAN_DIV=4, BLINK_FRAMES=2, active-low pins). Expected slot  |
// |               patterns are queued as stimulus is applied and popped as the |
// |               DUT lights each digit slot.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .digits_in  (digits_in),
    .load       (load),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Reference glyphs {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      4'hA: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue the expected pin pattern for one lit slot (active-low pins).
  task automatic push(input string tag, input int idx, input logic [3:0] v,
                      input bit dark, input bit dpv);
    slot_t s;
    s.an  = ~(4'b0001 << idx);
    s.seg = dark ? 7'h7F : ~glyph(v);
    s.dp  = dark ? 1'b1 : ~dpv;
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  // Advance to the first lit cycle of the next digit slot.
  task automatic wait_slot(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (an !== 4'hF && n < 64) begin @(negedge clk); n++; end
    while (an === 4'hF && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) ok = 1'b0;
  endtask

  task automatic drain();
    slot_t s;
    string t;
    bit    ok;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      t = tag_q.pop_front();
      wait_slot(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s: timeout waiting for a lit slot, an=%b", t, an);
        exp_q.delete();
        tag_q.delete();
      end else begin
        check(t, {an, seg, dp}, s);
      end
    end
  endtask

  task automatic sync_slot(input int idx);
    bit         ok;
    logic [3:0] want;
    int         tries;
    want  = ~(4'b0001 << idx);
    tries = 0;
    do begin
      wait_slot(ok);
      tries++;
    end while (ok && an !== want && tries < 8);
    if (!ok || an !== want) begin
      n_checks++;
      n_fail++;
      $error("FAIL sync_slot%0d: observed an %b expected %b", idx, an, want);
    end
  endtask

  task automatic wait_frame_done(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an",  {8'h00, an},   12'h00F);
    check("rst_seg", {5'h00, seg},  12'h07F);
    check("rst_dp",  {11'h000, dp}, 12'h001);
    check("rst_fd",  {11'h000, frame_done}, 12'h000);

    // 1: load 1234 in frame 0; frame 0 shows cleared active, frame 1 shows 1234
    resetn    = 1'b1;
    digits_in = 16'h1234;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i < 4; i++) push("f0_zero", i, 4'd0, 1'b0, 1'b0);
    push("t1_d0", 0, 4'd4, 1'b0, 1'b0);
    push("t1_d1", 1, 4'd3, 1'b0, 1'b0);
    push("t1_d2", 2, 4'd2, 1'b0, 1'b0);
    push("t1_d3", 3, 4'd1, 1'b0, 1'b0);
    drain();

    // frame_done period
    wait_frame_done(n);
    @(negedge clk);
    wait_frame_done(n);
    check("fd_period", 12'(n + 1), 12'd16);

    // 2: repeated load mid-frame at idx=1; last value wins, no mixed frame
    sync_slot(1);
    digits_in = 16'h0000;
    load      = 1'b1;
    @(negedge clk);
    digits_in = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    push("t2_old_d2", 2, 4'd2, 1'b0, 1'b0);
    push("t2_old_d3", 3, 4'd1, 1'b0, 1'b0);
    push("t2_new_d0", 0, 4'd8, 1'b0, 1'b0);
    push("t2_new_d1", 1, 4'd7, 1'b0, 1'b0);
    push("t2_new_d2", 2, 4'd6, 1'b0, 1'b0);
    push("t2_new_d3", 3, 4'd5, 1'b0, 1'b0);
    drain();

    // 3: load exactly on the wrap edge (16 cycles after the previous wrap)
    wait_frame_done(n);
    repeat (15) @(negedge clk);
    digits_in = 16'h9A00;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("t3_pending", {11'h000, dut.r_pending}, 12'h000);
    check("t3_fd",      {11'h000, frame_done},    12'h001);
    push("t3_d0", 0, 4'd0, 1'b0, 1'b0);
    push("t3_d1", 1, 4'd0, 1'b0, 1'b0);
    push("t3_d2", 2, 4'hA, 1'b0, 1'b0);
    push("t3_d3", 3, 4'd9, 1'b0, 1'b0);
    drain();

    // 5: digit 0 = 8 with decimal point, active-low pins, then the gap cycle
    dp_mask   = 4'b0001;
    digits_in = 16'h0008;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push("t5_d0_8dp", 0, 4'd8, 1'b0, 1'b1);
    push("t5_d1", 1, 4'd0, 1'b0, 1'b0);
    push("t5_d2", 2, 4'd0, 1'b0, 1'b0);
    push("t5_d3", 3, 4'd0, 1'b0, 1'b0);
    drain();
    n = 0;
    while (an !== 4'hF && n < 16) begin @(negedge clk); n++; end
    check("t5_gap", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    dp_mask = 4'b0000;

    // 6: asynchronous reset mid-scan
    sync_slot(2);
    #2 resetn = 1'b0;
    #1;
    check("t6_an",  {8'h00, an},   12'h00F);
    check("t6_seg", {5'h00, seg},  12'h07F);
    check("t6_dp",  {11'h000, dp}, 12'h001);
    check("t6_fd",  {11'h000, frame_done}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // 4: blink digit 0 (2 frames dark / 2 lit), blank digit 3 always
    blink_mask = 4'b0001;
    blank_mask = 4'b1000;
    digits_in  = 16'h1357;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push("t6_first_d1", 1, 4'd0, 1'b0, 1'b0);
    push("t6_d2", 2, 4'd0, 1'b0, 1'b0);
    push("t4_blank_d3", 3, 4'd0, 1'b1, 1'b0);
    for (int f = 1; f < 6; f++) begin
      push("t4_blink_d0", 0, 4'd7, (f == 2 || f == 3), 1'b0);
      push("t4_d1", 1, 4'd5, 1'b0, 1'b0);
      push("t4_d2", 2, 4'd3, 1'b0, 1'b0);
      push("t4_blank_d3", 3, 4'd1, 1'b1, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
